// File: rtl/gb_apu_pkg.sv
// Shared types and step-decode tables for the APU frame sequencer.
package gb_apu_pkg;

  localparam int unsigned NUM_STEPS     = 8;
  localparam int unsigned FRAME_DIV_TAP = 12;

  typedef logic [2:0] frame_step_t;

  // Bit n set means step n produces that strobe.
  localparam logic [NUM_STEPS-1:0] STEP_LENGTH_MASK = 8'b0101_0101;
  localparam logic [NUM_STEPS-1:0] STEP_SWEEP_MASK  = 8'b0100_0100;
  localparam logic [NUM_STEPS-1:0] STEP_ENV_MASK    = 8'b1000_0000;

  typedef struct packed {
    logic length;
    logic sweep;
    logic envelope;
  } frame_strobes_t;

  function automatic frame_strobes_t decode_step(input frame_step_t step);
    frame_strobes_t s;
    s.length   = STEP_LENGTH_MASK[step];
    s.sweep    = STEP_SWEEP_MASK[step];
    s.envelope = STEP_ENV_MASK[step];
    return s;
  endfunction

endpackage

// File: rtl/gb_apu_div_counter.sv
// Free-running system-clock divider with tap register; flags the tap's falling edge.
module gb_apu_div_counter
  import gb_apu_pkg::*;
#(
  parameter int unsigned DIV_TAP_BIT = FRAME_DIV_TAP
) (
  input  logic clk,
  input  logic reset,
  input  logic div_reset,
  output logic evt
);

  localparam int unsigned CNT_W = DIV_TAP_BIT + 1;

  logic [CNT_W-1:0] div_cnt;
  logic             tap;
  logic             tap_q;

  assign tap = div_cnt[DIV_TAP_BIT];
  // A DIV write while the tap is high drops it to 0 and yields an early event.
  assign evt = tap_q & ~tap;

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      tap_q   <= 1'b0;
    end else begin
      if (div_reset) div_cnt <= '0;
      else           div_cnt <= div_cnt + CNT_W'(1);
      tap_q <= tap;
    end
  end

endmodule

// File: rtl/gb_apu_frame_sequencer.sv
// 512 Hz frame sequencer producing length/sweep/envelope strobes for the APU channels.
// Define GB_APU_EXT_DIV_EN to take the divider tap from an external div_bit input.
module gb_apu_frame_sequencer
  import gb_apu_pkg::*;
#(
  parameter int unsigned DIV_TAP_BIT = FRAME_DIV_TAP
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       apu_enable,
  input  logic       div_reset,
`ifdef GB_APU_EXT_DIV_EN
  input  logic       div_bit,
`endif
  output logic       clk_length,
  output logic       clk_sweep,
  output logic       clk_envelope,
  output logic [2:0] frame_step,
  output logic       next_step_no_length
);

  logic           frame_evt;
  frame_step_t    step_q, step_d;
  frame_strobes_t strb_q, strb_d;

`ifdef GB_APU_EXT_DIV_EN
  logic div_q1;
  logic div_q2;
  logic unused_div_reset;

  // The timer block owns DIV, so its reset pulse has no effect here.
  assign unused_div_reset = div_reset;
  assign frame_evt        = div_q2 & ~div_q1;

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q1 <= 1'b0;
      div_q2 <= 1'b0;
    end else begin
      div_q1 <= div_bit;
      div_q2 <= div_q1;
    end
  end
`else
  gb_apu_div_counter #(
    .DIV_TAP_BIT (DIV_TAP_BIT)
  ) u_div_counter (
    .clk       (clk),
    .reset     (reset),
    .div_reset (div_reset),
    .evt       (frame_evt)
  );
`endif

  // Power-off wins over an event landing in the same cycle.
  always_comb begin
    step_d = step_q;
    strb_d = '0;
    if (!apu_enable) begin
      step_d = '0;
    end else if (frame_evt) begin
      strb_d = decode_step(step_q);
      step_d = step_q + 3'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      step_q <= '0;
      strb_q <= '0;
    end else begin
      step_q <= step_d;
      strb_q <= strb_d;
    end
  end

  assign clk_length          = strb_q.length;
  assign clk_sweep           = strb_q.sweep;
  assign clk_envelope        = strb_q.envelope;
  assign frame_step          = step_q;
  assign next_step_no_length = step_q[0];

endmodule

// File: tb/tb_gb_apu_frame_sequencer.sv
// Directed bench for gb_apu_frame_sequencer with a 16-cycle frame period (DIV_TAP_BIT=3).
module tb_gb_apu_frame_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       apu_enable;
  logic       div_reset;
`ifdef GB_APU_EXT_DIV_EN
  logic       div_bit = 1'b0;
`endif
  logic       clk_length;
  logic       clk_sweep;
  logic       clk_envelope;
  logic [2:0] frame_step;
  logic       next_step_no_length;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  gb_apu_frame_sequencer #(
    .DIV_TAP_BIT (3)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .apu_enable          (apu_enable),
    .div_reset           (div_reset),
`ifdef GB_APU_EXT_DIV_EN
    .div_bit             (div_bit),
`endif
    .clk_length          (clk_length),
    .clk_sweep           (clk_sweep),
    .clk_envelope        (clk_envelope),
    .frame_step          (frame_step),
    .next_step_no_length (next_step_no_length)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic adv(input int target);
    while (cyc < target) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Every cycle up to target must show no strobe and the given frame_step.
  task automatic run_quiet(input int target, input logic [2:0] exp_fs, input string tag);
    int bad = 0;
    while (cyc < target) begin
      @(negedge clk);
      cyc++;
      if ({clk_length, clk_sweep, clk_envelope} != 3'b000 || frame_step !== exp_fs) bad++;
    end
    chk(tag, 32'(bad), 32'd0);
  endtask

  function automatic logic [2:0] les();
    return {clk_length, clk_sweep, clk_envelope};
  endfunction

  initial begin
    logic [2:0] exp_les [8];
    int         stray;
    int         s;

    // {length, sweep, envelope} per step
    exp_les = '{3'b100, 3'b000, 3'b110, 3'b000, 3'b100, 3'b000, 3'b110, 3'b001};

    reset      = 1'b1;
    apu_enable = 1'b1;
    div_reset  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_strobes", 32'(les()), 32'd0);
    chk("rst_frame_step", 32'(frame_step), 32'd0);
    chk("rst_no_length", 32'(next_step_no_length), 32'd0);
    reset = 1'b0;
    cyc   = 0;

    // Full 8-step sequence: events at cycle 17 + 16*k after reset release.
    stray = 0;
    for (int c = 1; c <= 129; c++) begin
      @(negedge clk);
      cyc++;
      if (c >= 17 && ((c - 17) % 16) == 0) begin
        s = (c - 17) / 16;
        chk($sformatf("seq_strobes_step%0d", s), 32'(les()), 32'(exp_les[s]));
        chk($sformatf("seq_frame_step_after%0d", s), 32'(frame_step), 32'((s + 1) % 8));
        chk($sformatf("seq_no_length_after%0d", s), 32'(next_step_no_length), 32'((s + 1) % 2));
      end else if (les() != 3'b000) begin
        stray++;
      end
    end
    chk("seq_no_stray_strobes", 32'(stray), 32'd0);

    // DIV write while tap is high (div_cnt=10): early step 0.
    adv(138);
    div_reset = 1'b1;
    adv(139);
    div_reset = 1'b0;
    chk("divhi_no_strobe_yet", 32'(les()), 32'd0);
    chk("divhi_fs_before", 32'(frame_step), 32'd0);
    adv(140);
    chk("divhi_strobe", 32'(les()), 32'b100);
    chk("divhi_fs_after", 32'(frame_step), 32'd1);
    run_quiet(155, 3'd1, "divhi_quiet");
    adv(156);
    chk("divhi_next_evt_fs", 32'(frame_step), 32'd2);
    chk("divhi_next_evt_strobe", 32'(les()), 32'd0);

    // DIV write while tap is low (div_cnt=2): no event, next one delayed.
    adv(157);
    div_reset = 1'b1;
    adv(158);
    div_reset = 1'b0;
    run_quiet(174, 3'd2, "divlo_delayed_quiet");
    adv(175);
    chk("divlo_strobe", 32'(les()), 32'b110);
    chk("divlo_fs_after", 32'(frame_step), 32'd3);

    // Power off at frame_step 5 for 40 cycles, then power on.
    adv(207);
    chk("pre_off_fs", 32'(frame_step), 32'd5);
    adv(210);
    apu_enable = 1'b0;
    run_quiet(250, 3'd0, "off_window");
    apu_enable = 1'b1;
    run_quiet(254, 3'd0, "on_wait");
    adv(255);
    chk("on_first_strobe", 32'(les()), 32'b100);
    chk("on_first_fs", 32'(frame_step), 32'd1);
    chk("on_no_length", 32'(next_step_no_length), 32'd1);

    // Power falls in the same cycle as an event.
    adv(270);
    chk("coinc_fs_before", 32'(frame_step), 32'd1);
    apu_enable = 1'b0;
    adv(271);
    chk("coinc_strobe", 32'(les()), 32'd0);
    chk("coinc_fs", 32'(frame_step), 32'd0);
    apu_enable = 1'b1;

    // Reset mid-period with frame_step 6.
    adv(367);
    chk("pre_rst_fs", 32'(frame_step), 32'd6);
    adv(375);
    reset = 1'b1;
    adv(376);
    reset = 1'b0;
    chk("mid_rst_strobes", 32'(les()), 32'd0);
    chk("mid_rst_fs", 32'(frame_step), 32'd0);
    chk("mid_rst_no_length", 32'(next_step_no_length), 32'd0);
    run_quiet(392, 3'd0, "post_rst_quiet");
    adv(393);
    chk("post_rst_strobe", 32'(les()), 32'b100);
    chk("post_rst_fs", 32'(frame_step), 32'd1);
    adv(394);
    chk("post_rst_pulse_width", 32'(les()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gb_apu_frame_sequencer.md
# gb_apu_frame_sequencer

Generates the one-cycle enable strobes that pace every APU channel function: the 256 Hz length clock, the 128 Hz sweep clock (`clk_sweep` into the channel 1 sweep function) and the 64 Hz envelope clock. It derives a 512 Hz event from a divider tap running on the 2^22 Hz system clock. It steps an 8-state frame sequencer on each event and decodes the strobes from the step. It sits between the timer/DIV logic and all four channels, and is gated by APU power (NR52 bit 7).

## Interface
Parameters:
- `DIV_TAP_BIT`, default 12. Divider bit whose falling edge is the frame event. 2^(12+1) cycles at 2^22 Hz gives 512 Hz. Lower values are for simulation only.

Ports:
- `clk`  in  1  system clock, 2^22 Hz.
- `reset`  in  1  synchronous, active-high.
- `apu_enable`  in  1  NR52 bit 7 (APU power).
- `div_reset`  in  1  one-cycle pulse on a CPU write to DIV.
- `div_bit`  in  1  external DIV tap. Present only with `GB_APU_EXT_DIV_EN`.
- `clk_length`  out  1  one-cycle length strobe.
- `clk_sweep`  out  1  one-cycle sweep strobe.
- `clk_envelope`  out  1  one-cycle envelope strobe.
- `frame_step`  out  3  index of the next step to execute.
- `next_step_no_length`  out  1  high when `frame_step` is odd, i.e. the next step does not clock length. Used by the length-enable quirk in the channels.

## Operation
- Divider: internal counter `div_cnt`, width `DIV_TAP_BIT+1`.
  - Increments every cycle and wraps freely.
  - Clears to 0 on `div_reset`.
  - Keeps running while `apu_enable` is low.
- Tap: `tap` is `div_cnt[DIV_TAP_BIT]`, or `div_bit` with the macro. It is registered into `tap_q`.
- Frame event: `evt = tap_q & ~tap`, a falling edge.
  - A `div_reset` while the tap is 1 therefore yields an event. This reproduces the hardware's early step.
- Step execution on `evt & apu_enable`: execute step `frame_step`, then set `frame_step <= frame_step + 1`, wrapping 7→0.
- Step decode:
  - 0: length.
  - 1: none.
  - 2: length and sweep.
  - 3: none.
  - 4: length.
  - 5: none.
  - 6: length and sweep.
  - 7: envelope.
- Power off (`apu_enable` low):
  - `frame_step` is forced to 0.
  - All strobes stay 0.
  - Events are discarded.
- Power on: the first event after `apu_enable` rises executes step 0.
- Priority, highest first: `reset`, then `~apu_enable`, then `evt`.
  - Event and power-off in the same cycle: no strobe, `frame_step` becomes 0.

## Timing
- Reset values:
  - All strobes 0.
  - `frame_step` 0.
  - `next_step_no_length` 0.
  - `div_cnt` 0.
  - `tap_q` 0. No spurious event is produced on the first cycle after reset.
- Latency: the tap is sampled low in cycle t with `tap_q` high. Strobes are registered and high in cycle t+1 for exactly one cycle. `frame_step` updates in the same cycle t+1.
- Internal divider period: one event every 2^(DIV_TAP_BIT+1) cycles, absent `div_reset`.
  - First event after reset: `div_cnt` wraps from all-ones at cycle 2^(DIV_TAP_BIT+1) − 1. The strobe follows 2 cycles later.
- Strobes never assert in consecutive cycles. At most one event occurs per divider period.
- `next_step_no_length` is combinational from `frame_step[0]` and is valid every cycle.

## Configuration
- `GB_APU_EXT_DIV_EN` defined:
  - `div_bit` port exists and is the tap.
  - Internal `div_cnt` is removed.
  - `div_reset` is ignored; the timer block owns DIV. Port kept for a uniform interface.
- Undefined:
  - No `div_bit` port.
  - Internal divider as above.

## Structure
- `gb_apu_pkg` holds:
  - `typedef logic [2:0] frame_step_t`.
  - Localparams `STEP_LENGTH_MASK = 8'b0101_0101`, `STEP_SWEEP_MASK = 8'b0100_0100`, `STEP_ENV_MASK = 8'b1000_0000`, indexed by step.
  - `FRAME_DIV_TAP = 12`.
- One sub-module, `gb_apu_div_counter`: the internal divider plus tap register and falling-edge detect. It outputs `evt`. It is instantiated only when `GB_APU_EXT_DIV_EN` is undefined; otherwise a 2-flop edge detect on `div_bit` is used inline.

## Test plan
- `DIV_TAP_BIT=3`, `apu_enable=1` from reset, 16·8 cycles: strobe order is L, –, L+S, –, L, –, L+S, E.
  - 16-cycle spacing between steps.
  - `clk_sweep` on steps 2 and 6 only.
  - Each pulse exactly 1 cycle wide.
- `div_reset` pulsed when `div_cnt=0b1010` (tap high): one event, strobe 2 cycles later, `frame_step` advances by 1. The next event arrives 16 cycles after the clear.
- `div_reset` pulsed when `div_cnt=0b0010` (tap low): no event, and the next event is delayed.
- `apu_enable` dropped when `frame_step=5`, held for 40 cycles, then raised:
  - No strobes while off.
  - `frame_step` reads 0 while off.
  - The first strobe after power-on is `clk_length` (step 0).
- `apu_enable` falls in the same cycle as `evt`: no strobe, `frame_step=0`.
- `reset` asserted mid-period with `frame_step=6`: next cycle all outputs 0, `frame_step=0`, and the first event arrives after a full period. With `GB_APU_EXT_DIV_EN`, toggle `div_bit` with a period of 20 cycles: one step per falling edge.
